sprite_motion_ctrl: RTL and testbench

//  Parametrised sprite position controller for the RPG playfield.
//  - Converts 4-bit direction pad into a registered {hpos,vpos}.
//  - Rate-limited by an internal frame tick.
//  - Supports diagonals, bounds saturation and key auto-repeat (first step, hold delay, run).
//  - Sits between input debounce and the VGA sprite renderer/collision logic.

---
 rtl/rpg_move_pkg.sv | 38 +++
 rtl/tick_divider.sv | 29 ++
 rtl/sprite_motion_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rpg_move_pkg.sv
// Shared definitions for RPG sprite movement: pad bit indices, facing codes,
// motion FSM states and the pad-to-effective-direction helper.
package rpg_move_pkg;

    // Bit positions inside the {up,down,left,right} pad vector.
    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    // Facing codes reported to the renderer.
    localparam logic [1:0] FACE_UP    = 2'd0;
    localparam logic [1:0] FACE_DOWN  = 2'd1;
    localparam logic [1:0] FACE_LEFT  = 2'd2;
    localparam logic [1:0] FACE_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } motion_state_e;

    // Opposing keys on the same axis cancel each other; the other axis survives.
    function automatic logic [3:0] effective_dir(input logic [3:0] raw);
        logic [3:0] ed;
        ed = raw;
        if (raw[DIR_UP] && raw[DIR_DOWN]) begin
            ed[DIR_UP]   = 1'b0;
            ed[DIR_DOWN] = 1'b0;
        end
        if (raw[DIR_LEFT] && raw[DIR_RIGHT]) begin
            ed[DIR_LEFT]  = 1'b0;
            ed[DIR_RIGHT] = 1'b0;
        end
        return ed;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
// The counter runs 0..DIV-1; tick is high while the count sits at DIV-1.
module tick_divider #(
    parameter int DIV = 833333
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    // Count up and wrap to zero on the tick cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Sprite position controller: turns a debounced direction pad into a
// registered {hpos,vpos}, stepping once per movement tick with a first step,
// a hold delay and then continuous run (auto-repeat).
// Optional build macro SPRITE_MOTION_WRAP_EN: out-of-range steps wrap to the
// opposite bound (torus playfield) instead of saturating at the bound.
module sprite_motion_ctrl
    import rpg_move_pkg::*;
#(
    parameter int POS_W      = 10,
    parameter int H_MIN      = 0,
    parameter int H_MAX      = 615,
    parameter int V_MIN      = 0,
    parameter int V_MAX      = 455,
    parameter int INIT_H     = 463,
    parameter int INIT_V     = 270,
    parameter int STEP       = 5,
    parameter int TICK_DIV   = 833333,
    parameter int REPEAT_DLY = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         inputs,
    output logic [2*POS_W-1:0] position,
    output logic               moving,
    output logic [1:0]         facing,
    output logic               edge_hit
);

    // Two spare bits so pos-STEP and pos+STEP are representable as signed.
    localparam int CW = POS_W + 2;
    localparam int HW = (REPEAT_DLY > 0) ? $clog2(REPEAT_DLY + 1) : 1;

    localparam logic [POS_W-1:0] H_MIN_P  = POS_W'(H_MIN);
    localparam logic [POS_W-1:0] H_MAX_P  = POS_W'(H_MAX);
    localparam logic [POS_W-1:0] V_MIN_P  = POS_W'(V_MIN);
    localparam logic [POS_W-1:0] V_MAX_P  = POS_W'(V_MAX);
    localparam logic [POS_W-1:0] INIT_H_P = POS_W'(INIT_H);
    localparam logic [POS_W-1:0] INIT_V_P = POS_W'(INIT_V);
    localparam logic [CW-1:0]    STEP_P   = CW'(STEP);
    localparam logic [HW-1:0]    HOLD_LD  = HW'(REPEAT_DLY);

    motion_state_e     state_q;
    logic [HW-1:0]     hold_q;
    logic [3:0]        dir_q;
    logic [POS_W-1:0]  hpos_q, vpos_q;
    logic [1:0]        facing_q;
    logic              edge_hit_q;

    logic              tick;
    logic [3:0]        ed;
    logic              step_now;
    logic              h_hit, v_hit;
    logic [POS_W-1:0]  h_next, v_next;
    logic [1:0]        face_next;

    tick_divider #(.DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // One axis step: returns {hit, new_pos}; hit means the bound was crossed.
    function automatic logic [POS_W:0] step_axis(
        input logic [POS_W-1:0] pos,
        input logic             dec,
        input logic             inc,
        input logic [POS_W-1:0] lo,
        input logic [POS_W-1:0] hi
    );
        logic signed [CW-1:0] cand;
        logic signed [CW-1:0] lo_s;
        logic signed [CW-1:0] hi_s;
        logic                 hit;
        logic [POS_W-1:0]     res;
        cand = $signed({2'b00, pos});
        lo_s = $signed({2'b00, lo});
        hi_s = $signed({2'b00, hi});
        hit  = 1'b0;
        res  = pos;
        if (dec) begin
            cand = cand - $signed(STEP_P);
        end else if (inc) begin
            cand = cand + $signed(STEP_P);
        end
        if (cand < lo_s) begin
            hit = 1'b1;
`ifdef SPRITE_MOTION_WRAP_EN
            res = hi;
`else
            res = lo;
`endif
        end else if (cand > hi_s) begin
            hit = 1'b1;
`ifdef SPRITE_MOTION_WRAP_EN
            res = lo;
`else
            res = hi;
`endif
        end else begin
            res = cand[POS_W-1:0];
        end
        return {hit, res};
    endfunction

    // Effective direction, candidate positions and whether this tick steps.
    always_comb begin
        ed = effective_dir(inputs);
        {h_hit, h_next} = step_axis(hpos_q, ed[DIR_LEFT], ed[DIR_RIGHT], H_MIN_P, H_MAX_P);
        {v_hit, v_next} = step_axis(vpos_q, ed[DIR_UP], ed[DIR_DOWN], V_MIN_P, V_MAX_P);
        // Vertical component wins the facing on diagonals.
        face_next = facing_q;
        if (ed[DIR_UP])         face_next = FACE_UP;
        else if (ed[DIR_DOWN])  face_next = FACE_DOWN;
        else if (ed[DIR_LEFT])  face_next = FACE_LEFT;
        else if (ed[DIR_RIGHT]) face_next = FACE_RIGHT;
        step_now = 1'b0;
        if (tick && ed != 4'b0000) begin
            unique case (state_q)
                ST_IDLE: step_now = 1'b1;
                ST_HOLD: step_now = (ed != dir_q) || (hold_q == '0);
                ST_RUN:  step_now = 1'b1;
                default: step_now = 1'b0;
            endcase
        end
    end

    // Motion FSM: first step, hold delay countdown, then continuous run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            dir_q   <= '0;
        end else if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ed != 4'b0000) begin
                        hold_q  <= HOLD_LD;
                        dir_q   <= ed;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (ed == 4'b0000) begin
                        state_q <= ST_IDLE;
                    end else if (ed != dir_q) begin
                        hold_q <= HOLD_LD;
                        dir_q  <= ed;
                    end else if (hold_q != '0) begin
                        hold_q <= hold_q - 1'b1;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (ed == 4'b0000) begin
                        state_q <= ST_IDLE;
                    end else if (ed != dir_q) begin
                        hold_q  <= HOLD_LD;
                        dir_q   <= ed;
                        state_q <= ST_HOLD;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Position/facing update on each step; edge_hit lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hpos_q     <= INIT_H_P;
            vpos_q     <= INIT_V_P;
            facing_q   <= FACE_DOWN;
            edge_hit_q <= 1'b0;
        end else begin
            edge_hit_q <= 1'b0;
            if (step_now) begin
                hpos_q     <= h_next;
                vpos_q     <= v_next;
                facing_q   <= face_next;
                edge_hit_q <= h_hit | v_hit;
            end
        end
    end

    assign position = {hpos_q, vpos_q};
    assign moving   = (state_q != ST_IDLE);
    assign facing   = facing_q;
    assign edge_hit = edge_hit_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl with TICK_DIV=4, REPEAT_DLY=2, STEP=5.
// A second instance starts near the top-right corner to exercise the bounds.
// Expectations follow SPRITE_MOTION_WRAP_EN when the bench is built with it.
module tb_sprite_motion_ctrl;

    logic        clk;
    logic        rst_m, rst_e;
    logic [3:0]  in_m, in_e;
    logic [19:0] pos_m, pos_e;
    logic        mov_m, mov_e;
    logic [1:0]  face_m, face_e;
    logic        hit_m, hit_e;

    int checks   = 0;
    int failures = 0;

    sprite_motion_ctrl #(
        .TICK_DIV(4), .REPEAT_DLY(2), .STEP(5)
    ) u_dut (
        .clk(clk), .rst(rst_m), .inputs(in_m), .position(pos_m),
        .moving(mov_m), .facing(face_m), .edge_hit(hit_m)
    );

    sprite_motion_ctrl #(
        .TICK_DIV(4), .REPEAT_DLY(2), .STEP(5), .INIT_H(613), .INIT_V(3)
    ) u_dut_edge (
        .clk(clk), .rst(rst_e), .inputs(in_e), .position(pos_e),
        .moving(mov_e), .facing(face_e), .edge_hit(hit_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("chk  %s got=%0d", tag, got);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        cycles(4 * n);
    endtask

    task automatic reset_main(input logic [3:0] in);
        in_m  = in;
        rst_m = 1'b1;
        cycles(2);
        rst_m = 1'b0;
    endtask

    task automatic reset_edge(input logic [3:0] in);
        in_e  = in;
        rst_e = 1'b1;
        cycles(2);
        rst_e = 1'b0;
    endtask

    initial begin
        rst_m = 1'b1; rst_e = 1'b1;
        in_m  = 4'b0000; in_e = 4'b0000;
        @(negedge clk);

        // Reset state
        reset_main(4'b0000);
        check("rst_h", pos_m[19:10], 463);
        check("rst_v", pos_m[9:0], 270);
        check("rst_moving", mov_m, 0);
        check("rst_facing", face_m, 1);
        check("rst_edge", hit_m, 0);

        // Hold up: first step, two hold ticks, then run
        reset_main(4'b1000);
        ticks(1);
        check("up_t1_v", pos_m[9:0], 265);
        check("up_t1_h", pos_m[19:10], 463);
        check("up_t1_facing", face_m, 0);
        check("up_t1_moving", mov_m, 1);
        check("up_t1_edge", hit_m, 0);
        ticks(1);
        check("up_t2_v", pos_m[9:0], 265);
        ticks(1);
        check("up_t3_v", pos_m[9:0], 265);
        ticks(1);
        check("up_t4_v", pos_m[9:0], 260);
        ticks(1);
        check("up_t5_v", pos_m[9:0], 255);

        // Reset in RUN: immediate restore and tick counter restart
        cycles(1);
        check("run_moving", mov_m, 1);
        rst_m = 1'b1;
        cycles(1);
        rst_m = 1'b0;
        check("midrst_h", pos_m[19:10], 463);
        check("midrst_v", pos_m[9:0], 270);
        check("midrst_moving", mov_m, 0);
        check("midrst_facing", face_m, 1);
        cycles(3);
        check("midrst_pre_tick_v", pos_m[9:0], 270);
        cycles(1);
        check("midrst_tick_v", pos_m[9:0], 265);

        // Diagonal up-right
        reset_main(4'b1001);
        ticks(1);
        check("diag_ur_h", pos_m[19:10], 468);
        check("diag_ur_v", pos_m[9:0], 265);
        check("diag_ur_facing", face_m, 0);

        // Up+down cancels completely
        reset_main(4'b1100);
        for (int i = 0; i < 5; i++) begin
            ticks(1);
            check("updown_moving", mov_m, 0);
        end
        check("updown_h", pos_m[19:10], 463);
        check("updown_v", pos_m[9:0], 270);

        // Diagonal down-left: facing follows the vertical component
        reset_main(4'b0110);
        ticks(1);
        check("diag_dl_h", pos_m[19:10], 458);
        check("diag_dl_v", pos_m[9:0], 275);
        check("diag_dl_facing", face_m, 1);

        // Left+right cancel leaves nothing
        reset_main(4'b0011);
        ticks(1);
        check("lr_moving", mov_m, 0);
        check("lr_h", pos_m[19:10], 463);

        // Down with horizontal cancelled
        reset_main(4'b0111);
        ticks(1);
        check("down_lrc_h", pos_m[19:10], 463);
        check("down_lrc_v", pos_m[9:0], 275);

        // Direction change in HOLD is a new press, then release to IDLE
        reset_main(4'b1000);
        ticks(1);
        in_m = 4'b0001;
        ticks(1);
        check("chg_t2_h", pos_m[19:10], 468);
        check("chg_t2_v", pos_m[9:0], 265);
        check("chg_t2_facing", face_m, 3);
        ticks(2);
        check("chg_t4_h", pos_m[19:10], 468);
        ticks(1);
        check("chg_t5_h", pos_m[19:10], 473);
        check("chg_t5_moving", mov_m, 1);
        in_m = 4'b0000;
        ticks(1);
        check("rel_moving", mov_m, 0);
        check("rel_h", pos_m[19:10], 473);

        // Top bound: vpos 3 moving up
        reset_edge(4'b1000);
        ticks(1);
`ifdef SPRITE_MOTION_WRAP_EN
        check("top_v", pos_e[9:0], 455);
`else
        check("top_v", pos_e[9:0], 0);
`endif
        check("top_edge_pulse", hit_e, 1);
        cycles(1);
        check("top_edge_clear", hit_e, 0);
        cycles(11);
`ifdef SPRITE_MOTION_WRAP_EN
        check("top_again_v", pos_e[9:0], 450);
        check("top_again_edge", hit_e, 0);
`else
        check("top_again_v", pos_e[9:0], 0);
        check("top_again_edge", hit_e, 1);
`endif

        // Corner: up-right from {613,3} crosses both bounds
        reset_edge(4'b1001);
        ticks(1);
`ifdef SPRITE_MOTION_WRAP_EN
        check("corner_h", pos_e[19:10], 0);
        check("corner_v", pos_e[9:0], 455);
`else
        check("corner_h", pos_e[19:10], 615);
        check("corner_v", pos_e[9:0], 0);
`endif
        check("corner_edge", hit_e, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
